// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: receive-side bus of uart_rx_cfg.
// The master (receiver) drives the holding register, error pulses and busy;
// the slave (FIFO / CPU bridge) drives rx_ready.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;
    logic                 break_det;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun_err, break_det, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun_err, break_det, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable data width,
// parity and stop bits, frame/parity/overrun/break reporting and a
// valid/ready holding register towards the consumer.
// Optional feature macro: UART_RX_MAJORITY_EN -- when defined, every data,
// parity and stop bit is the 2-of-3 majority of the last three samples
// before bit centre; otherwise a single sample at bit centre is used.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    uart_rx_cfg_if.master bus
);
    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = 4;
    localparam logic [SCNT_W-1:0] SC_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SC_LAST = SCNT_W'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_div_chk
        $error("uart_rx_cfg: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
        $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_db_chk
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_fmt_chk
        $error("uart_rx_cfg: PARITY must be 0..2 and STOP_BITS 1..2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q;
    logic                 tick;
    logic [1:0]           sync_q;
    logic                 rx_sync;
    logic [SCNT_W-1:0]    scnt_q, scnt_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 bit_val, par_exp;
    logic                 done, ferr_fin, brk_ev, err_ev, good_ev, accept;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_o_q, frame_o_d;
    logic                 par_o_q, par_o_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_q, brk_d;

    // free-running divider producing one sample tick every DIV clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + DIV_W'(1);
    end
    assign tick = (div_q == DIV_W'(DIV - 1));

    // two-flop synchroniser for the asynchronous line, idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx};
    end
    assign rx_sync = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] mv_q;

    // keep the two samples taken just before bit centre for the vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_q <= 2'b11;
        end else if (tick) begin
            if (scnt_q == SCNT_W'(OVERSAMPLE - 3)) mv_q[0] <= rx_sync;
            if (scnt_q == SCNT_W'(OVERSAMPLE - 2)) mv_q[1] <= rx_sync;
        end
    end
    assign bit_val = (mv_q[0] & mv_q[1]) | (mv_q[0] & rx_sync) | (mv_q[1] & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    // expected parity bit over the assembled data word
    assign par_exp = (PARITY == 2) ? ~(^shift_q) : (^shift_q);

    // frame completion and its classification (break > error > good)
    assign done     = tick && (state_q == S_STOP) && (scnt_q == SC_LAST)
                      && (bcnt_q == BCNT_W'(STOP_BITS - 1));
    assign ferr_fin = ferr_q | ~bit_val;
    assign brk_ev   = done && (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && ferr_fin;
    assign err_ev   = done && !brk_ev && (ferr_fin || perr_q);
    assign good_ev  = done && !brk_ev && !ferr_fin && !perr_q;
    assign accept   = valid_q && bus.rx_ready;

    // state register together with the frame datapath it sequences
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            scnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // next state and datapath update, evaluated only on sample ticks
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_sync) begin
                        state_d = S_START;
                        scnt_d  = '0;
                    end
                end
                S_START: begin
                    if (scnt_q == SC_MID) begin
                        if (!rx_sync) begin
                            state_d   = S_DATA;
                            scnt_d    = '0;
                            bcnt_d    = '0;
                            par_bit_d = 1'b0;
                            perr_d    = 1'b0;
                            ferr_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (scnt_q == SC_LAST) begin
                        scnt_d  = '0;
                        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bcnt_q == BCNT_W'(DATA_BITS - 1)) begin
                            bcnt_d  = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bcnt_d = bcnt_q + BCNT_W'(1);
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (scnt_q == SC_LAST) begin
                        scnt_d    = '0;
                        par_bit_d = bit_val;
                        perr_d    = (bit_val != par_exp);
                        state_d   = S_STOP;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (scnt_q == SC_LAST) begin
                        scnt_d = '0;
                        if (!bit_val) ferr_d = 1'b1;
                        if (bcnt_q == BCNT_W'(STOP_BITS - 1)) begin
                            bcnt_d  = '0;
                            state_d = brk_ev ? S_BRK_WAIT : S_IDLE;
                        end else begin
                            bcnt_d = bcnt_q + BCNT_W'(1);
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                S_BRK_WAIT: begin
                    if (rx_sync) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // holding register and one-clock event pulses for the next clock
    always_comb begin
        valid_d   = valid_q && !accept;
        data_d    = data_q;
        frame_o_d = 1'b0;
        par_o_d   = 1'b0;
        ovr_d     = 1'b0;
        brk_d     = brk_ev;
        if (err_ev) begin
            frame_o_d = ferr_fin;
            par_o_d   = perr_q;
        end
        if (good_ev) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_o_q <= 1'b0;
            par_o_q   <= 1'b0;
            ovr_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            frame_o_q <= frame_o_d;
            par_o_q   <= par_o_d;
            ovr_q     <= ovr_d;
            brk_q     <= brk_d;
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.frame_err   = frame_o_q;
    assign bus.parity_err  = par_o_q;
    assign bus.overrun_err = ovr_q;
    assign bus.break_det   = brk_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receiver configurations (8N1, 8E1, 5O2) driven with
// directed and random frames; expected events go into a scoreboard queue
// and a monitor pops them as the receivers report results.
module tb_uart_rx_cfg;
    localparam int CLKF = 3_686_400;   // gives 2 clocks per sample tick
    localparam int BT   = 32;          // clocks per bit (16 ticks x 2)
    localparam int K_DATA = 0, K_FERR = 1, K_PERR = 2, K_OVR = 3, K_BRK = 4;

    typedef struct {
        int         unit;
        int         kind;
        logic [8:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_l = 3'b111;
    logic [2:0] rdy_man = 3'b111;
    logic [2:0] rnd_rdy = 3'b111;
    logic       rand_rdy = 1'b0;
    logic [2:0] rdy_w;
    logic [2:0] vld, bsy, fe, pe, ov, bk;
    logic [8:0] dat [3];
    exp_t       sbq[$];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rnd_rdy <= 3'($urandom);
    assign rdy_w = rand_rdy ? rnd_rdy : rdy_man;

    uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
    uart_rx_cfg_if #(.DATA_BITS(8)) ifb ();
    uart_rx_cfg_if #(.DATA_BITS(5)) ifc ();

    uart_rx_cfg #(.CLK_FREQ(CLKF), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1))
        u_a (.clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .bus(ifa));
    uart_rx_cfg #(.CLK_FREQ(CLKF), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1))
        u_b (.clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .bus(ifb));
    uart_rx_cfg #(.CLK_FREQ(CLKF), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(5),
                  .PARITY(2), .STOP_BITS(2))
        u_c (.clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .bus(ifc));

    assign ifa.rx_ready = rdy_w[0];
    assign ifb.rx_ready = rdy_w[1];
    assign ifc.rx_ready = rdy_w[2];
    assign vld = {ifc.rx_valid, ifb.rx_valid, ifa.rx_valid};
    assign bsy = {ifc.busy, ifb.busy, ifa.busy};
    assign fe  = {ifc.frame_err, ifb.frame_err, ifa.frame_err};
    assign pe  = {ifc.parity_err, ifb.parity_err, ifa.parity_err};
    assign ov  = {ifc.overrun_err, ifb.overrun_err, ifa.overrun_err};
    assign bk  = {ifc.break_det, ifb.break_det, ifa.break_det};
    assign dat[0] = {1'b0, ifa.rx_data};
    assign dat[1] = {1'b0, ifb.rx_data};
    assign dat[2] = {4'b0, ifc.rx_data};

    function automatic int db_of(input int u);   return (u == 2) ? 5 : 8; endfunction
    function automatic int par_of(input int u);  return u;                endfunction
    function automatic int stop_of(input int u); return (u == 2) ? 2 : 1; endfunction
    function automatic logic [8:0] mask_of(input int u);
        return (u == 2) ? 9'h01F : 9'h0FF;
    endfunction

    // correct parity bit for a word: even -> ones count odd, odd -> the inverse
    function automatic logic parity_of(input logic [8:0] d, input int par);
        logic ones_odd;
        ones_odd = ($countones(d) % 2) == 1;
        return (par == 2) ? !ones_odd : ones_odd;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic push(input int u, input int kind, input logic [8:0] d);
        exp_t e;
        e.unit = u;
        e.kind = kind;
        e.data = d;
        sbq.push_back(e);
    endtask

    // reference model: what one transmitted frame must produce
    task automatic expect_frame(input int u, input logic [8:0] d, input logic pbit,
                                input logic [1:0] st, input bit ovr);
        logic [8:0] dm;
        bit         f_err, p_err;
        dm    = d & mask_of(u);
        f_err = (st[0] == 1'b0) || (stop_of(u) == 2 && st[1] == 1'b0);
        p_err = (par_of(u) != 0) && (pbit != parity_of(dm, par_of(u)));
        if (dm == 9'd0 && (par_of(u) == 0 || pbit == 1'b0) && f_err) begin
            push(u, K_BRK, 9'd0);
        end else if (f_err || p_err) begin
            if (f_err) push(u, K_FERR, 9'd0);
            if (p_err) push(u, K_PERR, 9'd0);
        end else if (ovr) begin
            push(u, K_OVR, 9'd0);
        end else begin
            push(u, K_DATA, dm);
        end
    endtask

    // drive one frame clock by clock; glitch >= 0 inverts the line for 2 clocks there
    task automatic send_frame(input int u, input logic [8:0] d, input logic pbit,
                              input logic [1:0] st, input int glitch, input int gap_bits);
        logic [15:0] bits;
        int          nb;
        logic        v;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < db_of(u); i++) bits[1+i] = d[i];
        nb = 1 + db_of(u);
        if (par_of(u) != 0) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = st[0];
        nb++;
        if (stop_of(u) == 2) begin
            bits[nb] = st[1];
            nb++;
        end
        for (int k = 0; k < nb * BT; k++) begin
            v = bits[k / BT];
            if (glitch >= 0 && k >= glitch && k < glitch + 2) v = ~v;
            rx_l[u] = v;
            wait_clk(1);
        end
        rx_l[u] = 1'b1;
        wait_clk(gap_bits * BT);
    endtask

    function automatic string kname(input int k);
        case (k)
            K_DATA:  return "rx_valid";
            K_FERR:  return "frame_err";
            K_PERR:  return "parity_err";
            K_OVR:   return "overrun_err";
            default: return "break_det";
        endcase
    endfunction

    task automatic check_event(input int u, input int kind, input logic [8:0] d);
        int idx;
        idx = -1;
        n_vec++;
        foreach (sbq[i]) if (idx < 0 && sbq[i].unit == u && sbq[i].kind == kind) idx = i;
        if (idx < 0) begin
            n_err++;
            $display("FAIL unexpected_%s unit%0d: got pulse/data 0x%0h, required none", kname(kind), u, d);
        end else begin
            if (kind == K_DATA && sbq[idx].data !== d) begin
                n_err++;
                $display("FAIL rx_data unit%0d: got 0x%0h, required 0x%0h", u, d, sbq[idx].data);
            end
            sbq.delete(idx);
        end
    endtask

    task automatic monitor_loop();
        logic [2:0] pvld;
        logic [2:0] pacc;
        logic [8:0] pdat [3];
        pvld = '0;
        pacc = '0;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                if (rst_n) begin
                    if (vld[u] && rdy_w[u]) check_event(u, K_DATA, dat[u]);
                    if (fe[u]) check_event(u, K_FERR, 9'd0);
                    if (pe[u]) check_event(u, K_PERR, 9'd0);
                    if (ov[u]) check_event(u, K_OVR, 9'd0);
                    if (bk[u]) check_event(u, K_BRK, 9'd0);
                    if (vld[u] && pvld[u] && !pacc[u]) begin
                        n_vec++;
                        if (dat[u] !== pdat[u]) begin
                            n_err++;
                            $display("FAIL rx_data_hold unit%0d: got 0x%0h, required 0x%0h", u, dat[u], pdat[u]);
                        end
                    end
                end
                pvld[u] = vld[u];
                pacc[u] = vld[u] && rdy_w[u];
                pdat[u] = dat[u];
            end
        end
    endtask

    task automatic run_tests();
        logic [8:0] d, exp_d;
        logic       pb;
        logic [1:0] st;
        wait_clk(5);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("reset_valid%0d", u), 32'(vld[u]), 32'd0);
            chk($sformatf("reset_busy%0d", u), 32'(bsy[u]), 32'd0);
            chk($sformatf("reset_data%0d", u), 32'(dat[u]), 32'd0);
            chk($sformatf("reset_pulses%0d", u), 32'({fe[u], pe[u], ov[u], bk[u]}), 32'd0);
        end
        rst_n = 1'b1;
        wait_clk(10);

        // held word, then a single-clock accept
        rdy_man[0] = 1'b0;
        expect_frame(0, 9'hA5, 1'b0, 2'b11, 1'b0);
        send_frame(0, 9'hA5, 1'b0, 2'b11, -1, 2);
        chk("hold_valid", 32'(vld[0]), 32'd1);
        chk("hold_data", 32'(dat[0]), 32'hA5);
        wait_clk(20);
        chk("hold_valid_later", 32'(vld[0]), 32'd1);
        rdy_man[0] = 1'b1;
        wait_clk(1);
        rdy_man[0] = 1'b0;
        chk("valid_after_accept", 32'(vld[0]), 32'd0);

        // wrong even-parity bit on 0x37
        pb = parity_of(9'h37, 1) ^ 1'b1;
        expect_frame(1, 9'h37, pb, 2'b11, 1'b0);
        send_frame(1, 9'h37, pb, 2'b11, -1, 2);
        chk("perr_no_valid", 32'(vld[1]), 32'd0);

        // overrun: second word completes while the first is still held
        expect_frame(0, 9'h11, 1'b0, 2'b11, 1'b0);
        send_frame(0, 9'h11, 1'b0, 2'b11, -1, 1);
        expect_frame(0, 9'h22, 1'b0, 2'b11, 1'b1);
        send_frame(0, 9'h22, 1'b0, 2'b11, -1, 2);
        chk("ovr_kept_data", 32'(dat[0]), 32'h11);
        rdy_man[0] = 1'b1;
        wait_clk(1);
        chk("ovr_valid_after_accept", 32'(vld[0]), 32'd0);

        // line break for two frame times
        push(0, K_BRK, 9'd0);
        rx_l[0] = 1'b0;
        wait_clk(20 * BT);
        chk("brk_busy_low_line", 32'(bsy[0]), 32'd1);
        rx_l[0] = 1'b1;
        wait_clk(2 * BT);
        chk("brk_busy_after_high", 32'(bsy[0]), 32'd0);

        // short low pulse is rejected, following frame still received
        rx_l[0] = 1'b0;
        wait_clk(8);
        rx_l[0] = 1'b1;
        wait_clk(3 * BT);
        chk("glitch_busy", 32'(bsy[0]), 32'd0);
        expect_frame(0, 9'h5A, 1'b0, 2'b11, 1'b0);
        send_frame(0, 9'h5A, 1'b0, 2'b11, -1, 2);

        // one-tick high glitch at the centre of data bit 3 of 0x00
`ifdef UART_RX_MAJORITY_EN
        exp_d = 9'h00;
`else
        exp_d = 9'h08;
`endif
        expect_frame(0, exp_d, 1'b0, 2'b11, 1'b0);
        send_frame(0, 9'h00, 1'b0, 2'b11, BT * 4 + BT / 2, 2);

        // 5-bit odd parity, second stop bit low
        pb = parity_of(9'h15, 2);
        expect_frame(2, 9'h15, pb, 2'b01, 1'b0);
        send_frame(2, 9'h15, pb, 2'b01, -1, 2);
        chk("ferr_no_valid", 32'(vld[2]), 32'd0);

        // random frames on all three formats
        rand_rdy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int u = 0; u < 3; u++) begin
                d = 9'($urandom) & mask_of(u);
                if ($urandom_range(0, 7) == 0) d = 9'd0;
                st = 2'b11;
                if ($urandom_range(0, 7) == 0) st[0] = 1'b0;
                if ($urandom_range(0, 7) == 0) st[1] = 1'b0;
                pb = parity_of(d, par_of(u));
                if ($urandom_range(0, 7) == 0) pb = ~pb;
                expect_frame(u, d, pb, st, 1'b0);
                send_frame(u, d, pb, st, -1, 2);
            end
        end

        // reset in the middle of a frame
        rx_l[0] = 1'b0;
        wait_clk(3 * BT);
        rst_n = 1'b0;
        rx_l[0] = 1'b1;
        wait_clk(3);
        chk("midreset_busy", 32'(bsy[0]), 32'd0);
        chk("midreset_valid", 32'(vld[0]), 32'd0);
        rst_n = 1'b1;
        wait_clk(2 * BT);
        chk("after_reset_busy", 32'(bsy[0]), 32'd0);

        wait_clk(4 * BT);
        foreach (sbq[i]) begin
            $display("FAIL missing_%s unit%0d: got nothing, required data 0x%0h",
                     kname(sbq[i].kind), sbq[i].unit, sbq[i].data);
        end
        chk("scoreboard_left", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor_loop();
            run_tests();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
